// File: rtl/dmem_pipe.sv
// Pipelined single-port data memory: valid/ready requests, byte/half/word access, zero-fill sweep after reset.
// Optional build macro DMEM_MISALIGN_TRAP_EN turns misaligned half/word accesses into faults instead of aligning them.
//
// state  | meaning
// S_INIT | zero-fill sweep, one word per cycle; no requests accepted
// S_RUN  | requests accepted, one per cycle
module dmem_pipe #(
  parameter int DEPTH    = 2048,
  parameter int READ_LAT = 1
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic        req_write,
  input  logic [1:0]  req_size,
  input  logic        req_unsigned,
  input  logic [31:0] req_addr,
  input  logic [31:0] req_wdata,
  output logic        rsp_valid,
  output logic [31:0] rsp_rdata,
  output logic        rsp_err,
  output logic        busy
);

  localparam int AW = $clog2(DEPTH);
  localparam int L  = READ_LAT - 1;

  localparam logic [0:0] S_INIT = 1'b0;
  localparam logic [0:0] S_RUN  = 1'b1;

  logic [0:0]    state;
  logic [AW-1:0] sweep_cnt;
  logic [31:0]   mem [DEPTH];

  logic          accept;
  logic          fault;
  logic          misalign;
  logic          out_of_range;
  logic [1:0]    lane;
  logic [AW-1:0] idx;
  logic [3:0]    be;
  logic [31:0]   wdata_rep;

  logic          p_valid [READ_LAT];
  logic          p_err   [READ_LAT];
  logic          p_load  [READ_LAT];
  logic          p_uns   [READ_LAT];
  logic [1:0]    p_size  [READ_LAT];
  logic [1:0]    p_lane  [READ_LAT];
  logic [31:0]   p_raw   [READ_LAT];

  logic [7:0]    byte_sel;
  logic [15:0]   half_sel;
  logic [31:0]   ext;

  always_comb begin
    req_ready    = !rst && (state == S_RUN);
    busy         = rst || (state == S_INIT);
    accept       = req_valid && req_ready;
    out_of_range = |req_addr[31:AW+2];
    idx          = req_addr[AW+1:2];
    lane         = req_addr[1:0];
`ifdef DMEM_MISALIGN_TRAP_EN
    misalign = ((req_size == 2'b01) && req_addr[0]) ||
               ((req_size == 2'b10) && (req_addr[1:0] != 2'b00));
`else
    misalign = 1'b0;
    if (req_size == 2'b01)      lane[0] = 1'b0;
    else if (req_size == 2'b10) lane    = 2'b00;
`endif
    fault = out_of_range || (req_size == 2'b11) || misalign;
    case (req_size)
      2'b00: begin
        be        = 4'b0001 << lane;
        wdata_rep = {4{req_wdata[7:0]}};
      end
      2'b01: begin
        be        = lane[1] ? 4'b1100 : 4'b0011;
        wdata_rep = {2{req_wdata[15:0]}};
      end
      default: begin
        be        = 4'b1111;
        wdata_rep = req_wdata;
      end
    endcase
  end

  // Array and read-data path carry no reset so the RAM stays inferable.
  always_ff @(posedge clk) begin
    if (!rst && (state == S_INIT)) begin
      mem[sweep_cnt] <= '0;
    end else if (accept && req_write && !fault) begin
      for (int b = 0; b < 4; b++) begin
        if (be[b]) mem[idx][8*b +: 8] <= wdata_rep[8*b +: 8];
      end
    end
    if (accept && !req_write && !fault) p_raw[0] <= mem[idx];
    for (int i = 1; i < READ_LAT; i++) p_raw[i] <= p_raw[i-1];
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= S_INIT;
      sweep_cnt <= '0;
      for (int i = 0; i < READ_LAT; i++) begin
        p_valid[i] <= 1'b0;
        p_err[i]   <= 1'b0;
        p_load[i]  <= 1'b0;
        p_uns[i]   <= 1'b0;
        p_size[i]  <= 2'b00;
        p_lane[i]  <= 2'b00;
      end
    end else begin
      if (state == S_INIT) begin
        sweep_cnt <= sweep_cnt + AW'(1);
        if (sweep_cnt == AW'(DEPTH - 1)) state <= S_RUN;
      end
      p_valid[0] <= accept;
      p_err[0]   <= accept && fault;
      p_load[0]  <= accept && !req_write && !fault;
      p_uns[0]   <= req_unsigned;
      p_size[0]  <= req_size;
      p_lane[0]  <= lane;
      for (int i = 1; i < READ_LAT; i++) begin
        p_valid[i] <= p_valid[i-1];
        p_err[i]   <= p_err[i-1];
        p_load[i]  <= p_load[i-1];
        p_uns[i]   <= p_uns[i-1];
        p_size[i]  <= p_size[i-1];
        p_lane[i]  <= p_lane[i-1];
      end
    end
  end

  always_comb begin
    case (p_lane[L])
      2'd0:    byte_sel = p_raw[L][7:0];
      2'd1:    byte_sel = p_raw[L][15:8];
      2'd2:    byte_sel = p_raw[L][23:16];
      default: byte_sel = p_raw[L][31:24];
    endcase
    half_sel = p_lane[L][1] ? p_raw[L][31:16] : p_raw[L][15:0];
    case (p_size[L])
      2'b00:   ext = p_uns[L] ? {24'h0, byte_sel} : {{24{byte_sel[7]}}, byte_sel};
      2'b01:   ext = p_uns[L] ? {16'h0, half_sel} : {{16{half_sel[15]}}, half_sel};
      default: ext = p_raw[L];
    endcase
    rsp_valid = p_valid[L] && !rst;
    rsp_err   = rsp_valid && p_err[L];
    rsp_rdata = (rsp_valid && p_load[L]) ? ext : '0;
  end

endmodule

// File: tb/tb_dmem_pipe.sv
// Scoreboard bench for dmem_pipe: byte-array reference model, expected responses queued at issue,
// checked by an independent monitor including response cycle.
module tb_dmem_pipe;
  localparam int DEPTH    = 16;
  localparam int READ_LAT = 3;
  localparam int NB       = 4 * DEPTH;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        req_valid = 1'b0;
  logic        req_ready;
  logic        req_write = 1'b0;
  logic [1:0]  req_size = 2'b00;
  logic        req_unsigned = 1'b0;
  logic [31:0] req_addr = '0;
  logic [31:0] req_wdata = '0;
  logic        rsp_valid;
  logic [31:0] rsp_rdata;
  logic        rsp_err;
  logic        busy;

  dmem_pipe #(.DEPTH(DEPTH), .READ_LAT(READ_LAT)) dut (
    .clk(clk), .rst(rst),
    .req_valid(req_valid), .req_ready(req_ready), .req_write(req_write),
    .req_size(req_size), .req_unsigned(req_unsigned), .req_addr(req_addr),
    .req_wdata(req_wdata), .rsp_valid(rsp_valid), .rsp_rdata(rsp_rdata),
    .rsp_err(rsp_err), .busy(busy)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [31:0] data;
    logic        err;
    int          cyc;
  } exp_t;

  exp_t       sbq[$];
  logic [7:0] mb [NB];
  int         total = 0;
  int         bad = 0;
  int         cyc = 0;

  always @(posedge clk) cyc++;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    total++;
    if (act !== req) begin
      bad++;
      $display("FAIL %s: got %h, required %h (cycle %0d)", name, act, req, cyc);
    end
  endtask

  // Memory as a flat little-endian byte array; accesses computed from size/alignment arithmetic.
  task automatic model(input logic w, input logic [1:0] sz, input logic u, input logic [31:0] a,
                       input logic [31:0] wd, output logic [31:0] rd, output logic e);
    int n;
    int base;
    logic [31:0] v;
    n  = 1 << sz;
    e  = (a >= NB) || (sz == 2'b11);
    rd = '0;
`ifdef DMEM_MISALIGN_TRAP_EN
    if (sz != 2'b11 && (a % n) != 0) e = 1'b1;
    base = a;
`else
    base = (sz == 2'b11) ? 0 : int'(a - (a % n));
`endif
    if (!e) begin
      if (w) begin
        for (int k = 0; k < n; k++) mb[base + k] = wd[8*k +: 8];
      end else begin
        v = '0;
        for (int k = 0; k < n; k++) v = v | (32'(mb[base + k]) << (8 * k));
        if (n < 4 && !u && v[8*n-1]) v = v | ~((32'h1 << (8 * n)) - 32'h1);
        rd = v;
      end
    end
  endtask

  always @(posedge clk) begin
    exp_t e;
    #2;
    if (rsp_valid) begin
      if (sbq.size() == 0) begin
        total++;
        bad++;
        $display("FAIL unexpected_rsp: got rdata=%h err=%b, required no response (cycle %0d)",
                 rsp_rdata, rsp_err, cyc);
      end else begin
        e = sbq.pop_front();
        chk("rsp_rdata", rsp_rdata, e.data);
        chk("rsp_err", 32'(rsp_err), 32'(e.err));
        chk("rsp_cycle", cyc, e.cyc);
      end
    end else begin
      chk("idle_rdata", rsp_rdata, 32'h0);
      chk("idle_err", 32'(rsp_err), 32'h0);
    end
  end

  task automatic issue(input logic w, input logic [1:0] sz, input logic u,
                       input logic [31:0] a, input logic [31:0] wd);
    int   n;
    exp_t x;
    @(negedge clk);
    req_valid    = 1'b1;
    req_write    = w;
    req_size     = sz;
    req_unsigned = u;
    req_addr     = a;
    req_wdata    = wd;
    #1;
    n = 0;
    while (!req_ready && n < 4 * DEPTH) begin
      @(negedge clk);
      #1;
      n++;
    end
    if (!req_ready) begin
      total++;
      bad++;
      $display("FAIL ready_timeout: got req_ready=0 after %0d cycles, required 1", n);
      req_valid = 1'b0;
    end else begin
      model(w, sz, u, a, wd, x.data, x.err);
      x.cyc = cyc + READ_LAT;
      sbq.push_back(x);
    end
  endtask

  task automatic idle(input int n);
    @(negedge clk);
    req_valid = 1'b0;
    repeat (n - 1) @(negedge clk);
  endtask

  task automatic do_reset(input int n);
    int cnt;
    @(negedge clk);
    rst       = 1'b1;
    req_valid = 1'b0;
    sbq.delete();
    for (int i = 0; i < NB; i++) mb[i] = 8'h00;
    repeat (n) @(negedge clk);
    #1;
    chk("rst_rsp_valid", 32'(rsp_valid), 32'h0);
    chk("rst_req_ready", 32'(req_ready), 32'h0);
    chk("rst_busy", 32'(busy), 32'h1);
    chk("rst_rdata", rsp_rdata, 32'h0);
    chk("rst_err", 32'(rsp_err), 32'h0);
    rst = 1'b0;
    #1;
    cnt = 0;
    while (busy && cnt < 4 * DEPTH) begin
      cnt++;
      @(negedge clk);
      #1;
    end
    chk("sweep_len", cnt, DEPTH);
    chk("ready_after_sweep", 32'(req_ready), 32'h1);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: got no finish by time limit, required finish");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [31:0] a;
    do_reset(3);
    issue(1'b0, 2'b10, 1'b0, 32'h3C, 32'h0);
    issue(1'b1, 2'b10, 1'b0, 32'h10, 32'h3F78F5C3);
    issue(1'b1, 2'b00, 1'b0, 32'h12, 32'h80);
    issue(1'b0, 2'b00, 1'b0, 32'h12, 32'h0);
    issue(1'b0, 2'b00, 1'b1, 32'h12, 32'h0);
    issue(1'b0, 2'b10, 1'b0, 32'h10, 32'h0);
    issue(1'b0, 2'b01, 1'b0, 32'h12, 32'h0);
    issue(1'b0, 2'b01, 1'b1, 32'h10, 32'h0);
    for (int i = 0; i < 4; i++) issue(1'b1, 2'b10, 1'b0, 32'(4 * i), 32'(i + 1));
    idle(2);
    for (int i = 0; i < 4; i++) issue(1'b0, 2'b10, 1'b0, 32'(4 * i), 32'h0);
    idle(2);
    issue(1'b1, 2'b10, 1'b0, NB, 32'hDEADBEEF);
    issue(1'b1, 2'b10, 1'b0, 32'h2000, 32'hDEADBEEF);
    issue(1'b0, 2'b10, 1'b0, 32'h0, 32'h0);
    issue(1'b0, 2'b00, 1'b0, NB - 1, 32'h0);
    issue(1'b1, 2'b11, 1'b0, 32'h8, 32'hFFFFFFFF);
    issue(1'b0, 2'b11, 1'b0, 32'h8, 32'h0);
    issue(1'b0, 2'b10, 1'b0, 32'h8, 32'h0);
    issue(1'b1, 2'b10, 1'b0, 32'h4, 32'h11223344);
    issue(1'b0, 2'b10, 1'b0, 32'h6, 32'h0);
    issue(1'b0, 2'b01, 1'b0, 32'h7, 32'h0);
    issue(1'b1, 2'b01, 1'b0, 32'h5, 32'h0000ABCD);
    issue(1'b0, 2'b10, 1'b0, 32'h4, 32'h0);
    idle(READ_LAT + 2);
    issue(1'b0, 2'b10, 1'b0, 32'h0, 32'h0);
    issue(1'b0, 2'b10, 1'b0, 32'h4, 32'h0);
    do_reset(2);
    issue(1'b0, 2'b10, 1'b0, 32'h4, 32'h0);
    for (int i = 0; i < 400; i++) begin
      if (i == 200) begin
        issue(1'b0, 2'b10, 1'b0, 32'h0, 32'h0);
        do_reset(1);
      end
      if ($urandom_range(0, 3) == 0) begin
        idle(1);
      end else begin
        a = ($urandom_range(0, 9) == 0) ? $urandom : 32'($urandom_range(0, NB + 3));
        issue(1'($urandom_range(0, 1)), 2'($urandom_range(0, 3)), 1'($urandom_range(0, 1)),
              a, $urandom);
      end
    end
    idle(READ_LAT + 3);
    chk("queue_drained", 32'(sbq.size()), 32'h0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
